i2c_edid_byte_engine: RTL and testbench

Bit-level I2C slave engine for the HDMI-input EDID path. It samples the raw DDC SCL/SDA lines, detects START/STOP, and shifts bytes in or out under one-byte commands from the EDID protocol controller. It reports each byte and its ACK phase back to that controller. It sits between the DDC pads (open-drain SDA buffer) and the protocol controller; SCL is input-only, with no clock stretching.

---
 rtl/i2c_edid_byte_engine_if.sv | 34 +++
 rtl/i2c_edid_byte_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_edid_byte_engine.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_edid_byte_engine_if.sv
// ============================================================================
// Module  : i2c_edid_byte_engine_if
// Purpose : Command/status bundle between the EDID protocol controller and the
//           I2C byte engine.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface i2c_edid_byte_engine_if;
    logic       start_operation;
    logic       tx_data;
    logic [7:0] tx_byte;
    logic       generate_ack;
    logic [7:0] data_received;
    logic       byte_received;
    logic       operation_completed;
    logic       start_cond;
    logic       stop_cond;
    logic       line_ack;

    modport master (
        output start_operation, tx_data, tx_byte, generate_ack,
        input  data_received, byte_received, operation_completed,
               start_cond, stop_cond, line_ack
    );

    modport slave (
        input  start_operation, tx_data, tx_byte, generate_ack,
        output data_received, byte_received, operation_completed,
               start_cond, stop_cond, line_ack
    );
endinterface

`default_nettype wire

// File: rtl/i2c_edid_byte_engine.sv
// ============================================================================
// Module  : i2c_edid_byte_engine
// Purpose : Bit-level I2C slave engine: conditions DDC SCL/SDA, detects
//           START/STOP and moves one byte plus its ACK bit per command.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module i2c_edid_byte_engine #(
    parameter int FILTER_LEN = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              scl_in,
    input  wire logic              sda_in,
    output logic                   sda_drive_low,
    i2c_edid_byte_engine_if.slave  ctrl
);

    localparam logic [3:0] C_FILT_LAST = 4'(FILTER_LEN - 1);

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0] line_raw;
    logic [1:0] line_f;
    logic [1:0] line_rise;
    logic [1:0] line_fall;

    assign line_raw = {sda_in, scl_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        logic       sync1_q;
        logic       sync2_q;
        logic       filt_q;
        logic       filt_d;
        logic [3:0] cnt_q;
        logic [3:0] cnt_d;

        // A new level is accepted once it has disagreed with the filtered
        // level for FILTER_LEN consecutive cycles.
        always_comb begin
            filt_d = filt_q;
            cnt_d  = 4'd0;
            if (sync2_q != filt_q) begin
                if (cnt_q == C_FILT_LAST) begin
                    filt_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                filt_q  <= 1'b1;
                cnt_q   <= 4'd0;
            end else begin
                sync1_q <= line_raw[gi];
                sync2_q <= sync1_q;
                filt_q  <= filt_d;
                cnt_q   <= cnt_d;
            end
        end

        assign line_f[gi]    = filt_q;
        assign line_rise[gi] = ~filt_q & filt_d;
        assign line_fall[gi] =  filt_q & ~filt_d;
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    assign scl_f     = line_f[0];
    assign sda_f     = line_f[1];
    assign scl_rise  = line_rise[0];
    assign scl_fall  = line_fall[0];
    assign start_det = line_fall[1] & scl_f;
    assign stop_det  = line_rise[1] & scl_f;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_BITS = 3'd1,
        RX_ACK  = 3'd2,
        TX_BITS = 3'd3,
        TX_ACK  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       ack_pending_q, ack_pending_d;
    logic       sda_drive_low_q, sda_drive_low_d;
    logic [7:0] data_received_q, data_received_d;
    logic       line_ack_q, line_ack_d;
    logic       byte_received_q, byte_received_d;
    logic       operation_completed_q, operation_completed_d;
    logic       start_cond_q, start_cond_d;
    logic       stop_cond_q, stop_cond_d;

    always_comb begin
        state_d               = state_q;
        shift_d               = shift_q;
        bit_cnt_d             = bit_cnt_q;
        ack_pending_d         = ack_pending_q;
        sda_drive_low_d       = sda_drive_low_q;
        data_received_d       = data_received_q;
        line_ack_d            = line_ack_q;
        byte_received_d       = 1'b0;
        operation_completed_d = 1'b0;
        start_cond_d          = 1'b0;
        stop_cond_d           = 1'b0;

        // Bus conditions override any SCL edge seen in the same cycle.
        if (start_det || stop_det) begin
            start_cond_d    = start_det;
            stop_cond_d     = stop_det;
            sda_drive_low_d = 1'b0;
            ack_pending_d   = 1'b0;
            state_d         = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_drive_low_d = 1'b0;
                    if (ctrl.start_operation) begin
                        bit_cnt_d = 4'd0;
                        if (ctrl.tx_data) begin
                            shift_d         = ctrl.tx_byte;
                            sda_drive_low_d = ~ctrl.tx_byte[7];
                            state_d         = TX_BITS;
                        end else begin
                            state_d = RX_BITS;
                        end
                    end
                end
                RX_BITS: begin
                    if (ctrl.generate_ack && bit_cnt_q == 4'd8) begin
                        ack_pending_d = 1'b1;
                    end
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            data_received_d = {shift_q[6:0], sda_f};
                            byte_received_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_drive_low_d = ack_pending_d;
                        state_d         = RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_drive_low_d       = 1'b0;
                        ack_pending_d         = 1'b0;
                        operation_completed_d = 1'b1;
                        state_d               = IDLE;
                    end
                end
                TX_BITS: begin
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            sda_drive_low_d = 1'b0;
                            byte_received_d = 1'b1;
                            state_d         = TX_ACK;
                        end else begin
                            // Rotate so the next bit to send sits in bit 7.
                            shift_d         = {shift_q[6:0], shift_q[7]};
                            sda_drive_low_d = ~shift_q[6];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        line_ack_d = sda_f;
                    end else if (scl_fall) begin
                        operation_completed_d = 1'b1;
                        state_d               = IDLE;
                    end
                end
                default: begin
                    sda_drive_low_d = 1'b0;
                    state_d         = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q               <= IDLE;
            shift_q               <= 8'h00;
            bit_cnt_q             <= 4'd0;
            ack_pending_q         <= 1'b0;
            sda_drive_low_q       <= 1'b0;
            data_received_q       <= 8'h00;
            line_ack_q            <= 1'b1;
            byte_received_q       <= 1'b0;
            operation_completed_q <= 1'b0;
            start_cond_q          <= 1'b0;
            stop_cond_q           <= 1'b0;
        end else begin
            state_q               <= state_d;
            shift_q               <= shift_d;
            bit_cnt_q             <= bit_cnt_d;
            ack_pending_q         <= ack_pending_d;
            sda_drive_low_q       <= sda_drive_low_d;
            data_received_q       <= data_received_d;
            line_ack_q            <= line_ack_d;
            byte_received_q       <= byte_received_d;
            operation_completed_q <= operation_completed_d;
            start_cond_q          <= start_cond_d;
            stop_cond_q           <= stop_cond_d;
        end
    end

    assign sda_drive_low            = sda_drive_low_q;
    assign ctrl.data_received       = data_received_q;
    assign ctrl.byte_received       = byte_received_q;
    assign ctrl.operation_completed = operation_completed_q;
    assign ctrl.start_cond          = start_cond_q;
    assign ctrl.stop_cond           = stop_cond_q;
    assign ctrl.line_ack            = line_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_edid_byte_engine.sv
// ============================================================================
// Module  : tb_i2c_edid_byte_engine
// Purpose : Directed bench: an I2C master model on a wired-AND SDA line.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_edid_byte_engine;

    logic clk = 1'b0;
    logic rst;
    logic scl_m;
    logic sda_m;
    logic sda_ovr;
    logic ack_en;
    logic sda_drive_low;
    wire  sda_line;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_br   = 0;
    int cnt_oc   = 0;
    int cnt_sc   = 0;
    int cnt_pc   = 0;
    int cnt_drv  = 0;

    i2c_edid_byte_engine_if ctrl_if ();

    // Open-drain bus; the override lets the master force a level the slave pulls low.
    assign sda_line = sda_ovr ? sda_m : (sda_m & ~sda_drive_low);

    i2c_edid_byte_engine #(.FILTER_LEN(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .scl_in        (scl_m),
        .sda_in        (sda_line),
        .sda_drive_low (sda_drive_low),
        .ctrl          (ctrl_if.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ctrl_if.byte_received)       cnt_br  <= cnt_br + 1;
        if (ctrl_if.operation_completed) cnt_oc  <= cnt_oc + 1;
        if (ctrl_if.start_cond)          cnt_sc  <= cnt_sc + 1;
        if (ctrl_if.stop_cond)           cnt_pc  <= cnt_pc + 1;
        if (sda_drive_low)               cnt_drv <= cnt_drv + 1;
    end

    // Controller model: ACK request one cycle after byte_received when enabled.
    initial begin
        ctrl_if.generate_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ctrl_if.byte_received && ack_en) begin
                @(posedge clk); #1 ctrl_if.generate_ack = 1'b1;
                @(posedge clk); #1 ctrl_if.generate_ack = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic bit_cycle(input logic drv, output logic smp, output logic all_low);
        cyc(10);
        sda_m = drv;
        cyc(10);
        scl_m   = 1'b1;
        all_low = 1'b1;
        smp     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (sda_line) all_low = 1'b0;
            if (i == 10) smp = sda_line;
        end
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_smp, output logic ack_low);
        logic s, l;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s, l);
        bit_cycle(1'b1, ack_smp, ack_low);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] got);
        logic s, l;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s, l);
            got[i] = s;
        end
        bit_cycle(ack, s, l);
    endtask

    task automatic i2c_start();
        cyc(10); sda_m = 1'b1;
        cyc(10); scl_m = 1'b1;
        cyc(10); sda_m = 1'b0;
        cyc(10); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(10); sda_m = 1'b0;
        cyc(10); scl_m = 1'b1;
        cyc(10); sda_m = 1'b1;
        cyc(20);
    endtask

    task automatic start_op(input logic tx, input logic [7:0] b);
        ctrl_if.tx_data         = tx;
        ctrl_if.tx_byte         = b;
        ctrl_if.start_operation = 1'b1;
        cyc(1);
        ctrl_if.start_operation = 1'b0;
    endtask

    task automatic wait_oc(input string tag, input int base);
        for (int i = 0; i < 100 && cnt_oc == base; i++) cyc(1);
        check(tag, 32'(cnt_oc - base), 32'd1);
    endtask

    initial begin
        logic       as, al, s, l;
        logic [7:0] got;
        int         br0, oc0, sc0, pc0, drv0;

        rst     = 1'b1;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        sda_ovr = 1'b0;
        ack_en  = 1'b0;
        ctrl_if.start_operation = 1'b0;
        ctrl_if.tx_data         = 1'b0;
        ctrl_if.tx_byte         = 8'h00;
        cyc(5);
        check("rst_sda",   32'(sda_drive_low), 32'd0);
        check("rst_data",  32'(ctrl_if.data_received), 32'h00);
        check("rst_lack",  32'(ctrl_if.line_ack), 32'd1);
        check("rst_pulse", 32'({ctrl_if.byte_received, ctrl_if.operation_completed,
                                ctrl_if.start_cond, ctrl_if.stop_cond}), 32'd0);
        rst = 1'b0;
        cyc(20);
        check("rst_nocond", 32'(cnt_sc + cnt_pc), 32'd0);

        // Receive 0xA0 with ACK
        sc0 = cnt_sc;
        i2c_start();
        check("t1_start", 32'(cnt_sc - sc0), 32'd1);
        ack_en = 1'b1;
        br0 = cnt_br; oc0 = cnt_oc;
        start_op(1'b0, 8'h00);
        write_byte(8'hA0, as, al);
        check("t1_data",    32'(ctrl_if.data_received), 32'hA0);
        check("t1_br",      32'(cnt_br - br0), 32'd1);
        check("t1_ack",     32'(as), 32'd0);
        check("t1_ack_all", 32'(al), 32'd1);
        wait_oc("t1_oc", oc0);
        check("t1_release", 32'(sda_drive_low), 32'd0);

        // Receive 0x50 without ACK
        ack_en = 1'b0;
        br0 = cnt_br; oc0 = cnt_oc; drv0 = cnt_drv;
        start_op(1'b0, 8'h00);
        write_byte(8'h50, as, al);
        check("t2_data", 32'(ctrl_if.data_received), 32'h50);
        check("t2_br",   32'(cnt_br - br0), 32'd1);
        check("t2_nack", 32'(as), 32'd1);
        wait_oc("t2_oc", oc0);
        check("t2_nodrv", 32'(cnt_drv - drv0), 32'd0);

        // Transmit 0x00 (master ACK) then 0xFF (master NACK)
        br0 = cnt_br; oc0 = cnt_oc; pc0 = cnt_pc;
        start_op(1'b1, 8'h00);
        read_byte(1'b0, got);
        check("t3_byte0", 32'(got), 32'h00);
        wait_oc("t3_oc0", oc0);
        check("t3_lack0", 32'(ctrl_if.line_ack), 32'd0);
        oc0 = cnt_oc;
        start_op(1'b1, 8'hFF);
        read_byte(1'b1, got);
        check("t3_byte1", 32'(got), 32'hFF);
        wait_oc("t3_oc1", oc0);
        check("t3_lack1", 32'(ctrl_if.line_ack), 32'd1);
        check("t3_br",    32'(cnt_br - br0), 32'd2);
        i2c_stop();
        check("t3_stop", 32'(cnt_pc - pc0), 32'd1);

        // Repeated START after 3 received bits
        i2c_start();
        ack_en = 1'b1;
        start_op(1'b0, 8'h00);
        bit_cycle(1'b1, s, l);
        bit_cycle(1'b0, s, l);
        bit_cycle(1'b1, s, l);
        sc0 = cnt_sc; br0 = cnt_br; oc0 = cnt_oc;
        i2c_start();
        check("t4_start", 32'(cnt_sc - sc0), 32'd1);
        check("t4_nobr",  32'(cnt_br - br0), 32'd0);
        check("t4_nooc",  32'(cnt_oc - oc0), 32'd0);
        start_op(1'b0, 8'h00);
        write_byte(8'hA1, as, al);
        check("t4_data", 32'(ctrl_if.data_received), 32'hA1);
        check("t4_ack",  32'(as), 32'd0);
        wait_oc("t4_oc", oc0);

        // STOP while the engine is driving ACK
        start_op(1'b0, 8'h00);
        for (int i = 7; i >= 0; i--) bit_cycle(logic'((8'h3C >> i) & 8'h01), s, l);
        oc0 = cnt_oc;
        cyc(10); sda_m = 1'b0; sda_ovr = 1'b1;
        cyc(10); scl_m = 1'b1;
        cyc(10);
        check("t5_acking", 32'(sda_drive_low), 32'd1);
        sda_m = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ctrl_if.stop_cond) break;
        end
        check("t5_stop",    32'(ctrl_if.stop_cond), 32'd1);
        check("t5_release", 32'(sda_drive_low), 32'd0);
        cyc(2);
        sda_ovr = 1'b0;
        cyc(10);
        check("t5_nooc", 32'(cnt_oc - oc0), 32'd0);

        // Short SCL glitch must not shift a bit
        i2c_start();
        ack_en = 1'b1;
        start_op(1'b0, 8'h00);
        cyc(10); scl_m = 1'b1;
        cyc(3);  scl_m = 1'b0;
        cyc(10);
        br0 = cnt_br; oc0 = cnt_oc;
        write_byte(8'h5A, as, al);
        check("t6_data", 32'(ctrl_if.data_received), 32'h5A);
        check("t6_br",   32'(cnt_br - br0), 32'd1);
        wait_oc("t6_oc", oc0);
        ack_en = 1'b0;
        oc0 = cnt_oc;
        start_op(1'b1, 8'h3C);
        read_byte(1'b0, got);
        check("t6_tx", 32'(got), 32'h3C);
        wait_oc("t6_oc_tx", oc0);
        check("t6_lack", 32'(ctrl_if.line_ack), 32'd0);

        // Reset while SDA is held low
        start_op(1'b1, 8'h00);
        cyc(2);
        check("t6_drive", 32'(sda_drive_low), 32'd1);
        rst = 1'b1;
        cyc(1);
        check("t6_rst_sda",  32'(sda_drive_low), 32'd0);
        check("t6_rst_lack", 32'(ctrl_if.line_ack), 32'd1);
        check("t6_rst_data", 32'(ctrl_if.data_received), 32'h00);
        rst = 1'b0;
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
